// File: rtl/ram_core_dp.sv
// ram_core_dp -- simple dual-port synchronous RAM with registered read.
//
// One write port and one read port share a single clock. A read issued at
// edge N is registered at edge N and presented (rd_data, rd_valid) during
// cycle N+1. A same-cycle write and read to the same address is write-first:
// the read returns the incoming write data. When CLEAR_ON_RESET is set, every
// reset is followed by an INIT sweep that zeroes all DEPTH locations. Requests
// that arrive during the sweep are dropped and flagged with req_drop.
//
// Ports:
//   clk        clock, all logic on posedge
//   rstn       synchronous reset, active-high (1 = reset)
//   wr_en      write request
//   wr_addr    write address
//   wr_data    write data
//   rd_en      read request
//   rd_addr    read address
//   rd_data    registered read data (holds when no read)
//   rd_valid   one-cycle pulse per accepted read
//   init_busy  INIT sweep in progress
//   req_drop   one-cycle pulse: a request was dropped during INIT
module ram_core_dp #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  init_busy,
  output logic                  req_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  req_drop_q, req_drop_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    req_drop_d = 1'b0;

    unique case (state_q)
      INIT: begin
        req_drop_d = wr_en | rd_en;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = READY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READY: begin
        if (rd_en) begin
          rd_valid_d = 1'b1;
          // Write-first bypass: the array write lands on the same edge, so
          // forward the incoming word instead of the stale array entry.
          if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
          end else begin
            rd_data_d = mem_q[rd_addr];
          end
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? INIT : READY;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      req_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      req_drop_q <= req_drop_d;
    end
  end

  // Storage is never reset; it is only cleared by the INIT sweep.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      if (state_q == INIT) begin
        mem_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
      end else if (wr_en) begin
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign init_busy = (state_q == INIT);
  assign req_drop  = req_drop_q;

endmodule
